// File: rtl/bf_pkg.sv
// Shared types and default widths for the Bellman-Ford result checker and
// the bench plumbing around the bellmanford core.
package bf_pkg;

  // Width defaults shared with the bellmanford bench plumbing.
  localparam int BF_ADDR_W = 13;
  localparam int BF_OUT_W  = 16;

  // Checker FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bf_masked_compare.sv
// Masked word comparator: miss is high when any compared bit differs.
// A mask bit of 1 means the bit is compared, 0 means don't-care.
module bf_masked_compare #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] mask,
  output logic              miss
);

  assign miss = |((a ^ b) & mask);

endmodule

// File: rtl/bf_result_checker.sv
// Scans the DUT output memory against the expected memory one word per
// cycle. It applies a don't-care mask and reports pass/fail, a saturating
// mismatch count and the first failing address. It also records whether the
// NegCycle flags disagreed.
//
// Handshake: start is a level sampled on a rising clock edge only while the
// checker is IDLE or DONE; it is ignored while busy. done stays high until the
// next accepted start or reset. The results are stable while done is high.
module bf_result_checker
  import bf_pkg::*;
#(
  parameter int ADDR_W = BF_ADDR_W,
  parameter int DATA_W = BF_OUT_W,
  parameter int DEPTH  = 8192,
  parameter int CNT_W  = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] mask,
  input  logic              stop_on_first,
  input  logic              neg_cycle,
  input  logic              exp_neg_cycle,
  output logic [ADDR_W-1:0] act_addr,
  input  logic [DATA_W-1:0] act_data,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [ADDR_W-1:0] first_mismatch_addr,
  output logic              flag_mismatch,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic                stop_q, stop_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic                seen_q, seen_d;
  logic                flag_q, flag_d;

  logic [ADDR_W:0]     wc_clamp;
  logic [ADDR_W:0]     wc_last;
  logic                miss;
  logic                last_word;

  // Clamp the requested length to DEPTH. The last address is count-1. It
  // always fits ADDR_W bits because DEPTH <= 2^ADDR_W.
  always_comb begin
    wc_clamp = (word_count > DEPTH_W) ? DEPTH_W : word_count;
    wc_last  = wc_clamp - 1'b1;
  end

  bf_masked_compare #(.DATA_W(DATA_W)) u_cmp (
    .a    (act_data),
    .b    (exp_data),
    .mask (mask_q),
    .miss (miss)
  );

  assign last_word = (addr_q == last_q);

  // State, address counter, latched configuration and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      mask_q  <= '0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      stop_q  <= stop_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      seen_q  <= seen_d;
      flag_q  <= flag_d;
    end
  end

  // Next-state logic: accept start, then compare one word per cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    mask_d  = mask_q;
    stop_d  = stop_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    seen_d  = seen_q;
    flag_d  = flag_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mask_d  = mask;
          stop_d  = stop_on_first;
          addr_d  = '0;
          last_d  = wc_last[ADDR_W-1:0];
          cnt_d   = '0;
          first_d = '0;
          seen_d  = 1'b0;
          flag_d  = neg_cycle ^ exp_neg_cycle;
          // An empty scan goes straight to DONE and reports only the flags.
          state_d = (wc_clamp == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (miss) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (!seen_q) first_d = addr_q;
          seen_d = 1'b1;
        end
        // Hold the address on the last word so it never wraps.
        if (last_word || (miss && stop_q)) begin
          state_d = ST_DONE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign act_addr            = addr_q;
  assign exp_addr            = addr_q;
  assign busy                = (state_q == ST_SCAN);
  assign done                = (state_q == ST_DONE);
  assign pass                = done && (cnt_q == '0) && !flag_q;
  assign mismatch_count      = cnt_q;
  assign first_mismatch_addr = first_q;
  assign flag_mismatch       = flag_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_bf_result_checker.sv
// Directed bench for bf_result_checker. A default-sized instance covers the
// main scans. A small instance (DEPTH=32, CNT_W=4) covers saturation and
// length clamping.
module tb_bf_result_checker;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- shared stimulus ----------------
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [13:0] word_count = '0;
  logic [15:0] mask = '0;
  logic        stop_on_first = 1'b0;
  logic        neg_cycle = 1'b0, exp_neg_cycle = 1'b0;

  // ---------------- instance 1 (defaults) ----------------
  logic [12:0] act_addr1, exp_addr1;
  logic [15:0] act_data1, exp_data1;
  logic        busy1, done1, pass1, flag1;
  logic [13:0] cnt1;
  logic [12:0] first1;
  logic [1:0]  st1;
  logic [15:0] act_mem [16];
  logic [15:0] exp_mem [16];

  assign act_data1 = act_mem[act_addr1[3:0]];
  assign exp_data1 = exp_mem[exp_addr1[3:0]];

  bf_result_checker dut (
    .clock(clock), .reset(reset), .start(start1), .word_count(word_count),
    .mask(mask), .stop_on_first(stop_on_first), .neg_cycle(neg_cycle),
    .exp_neg_cycle(exp_neg_cycle), .act_addr(act_addr1), .act_data(act_data1),
    .exp_addr(exp_addr1), .exp_data(exp_data1), .busy(busy1), .done(done1),
    .pass(pass1), .mismatch_count(cnt1), .first_mismatch_addr(first1),
    .flag_mismatch(flag1), .dbg_state(st1)
  );

  // ---------------- instance 2 (small) ----------------
  logic [12:0] act_addr2, exp_addr2;
  logic [15:0] act_data2, exp_data2;
  logic        busy2, done2, pass2, flag2;
  logic [3:0]  cnt2;
  logic [12:0] first2;
  logic [1:0]  st2;

  // Every word differs from its expected value.
  assign act_data2 = {3'b000, act_addr2};
  assign exp_data2 = ~{3'b000, exp_addr2};

  bf_result_checker #(.DEPTH(32), .CNT_W(4)) dut_s (
    .clock(clock), .reset(reset), .start(start2), .word_count(word_count),
    .mask(mask), .stop_on_first(stop_on_first), .neg_cycle(neg_cycle),
    .exp_neg_cycle(exp_neg_cycle), .act_addr(act_addr2), .act_data(act_data2),
    .exp_addr(exp_addr2), .exp_data(exp_data2), .busy(busy2), .done(done2),
    .pass(pass2), .mismatch_count(cnt2), .first_mismatch_addr(first2),
    .flag_mismatch(flag2), .dbg_state(st2)
  );

  // Selected-instance view used by the driver task.
  logic        sel = 1'b0;
  logic        busy_m, done_m, pass_m;
  logic [13:0] cnt_m;
  logic [12:0] first_m, addr_m;
  always_comb begin
    busy_m  = sel ? busy2  : busy1;
    done_m  = sel ? done2  : done1;
    pass_m  = sel ? pass2  : pass1;
    cnt_m   = sel ? {10'b0, cnt2} : cnt1;
    first_m = sel ? first2 : first1;
    addr_m  = sel ? act_addr2 : act_addr1;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  task automatic ck(input string tag, input logic [W-1:0] obs, input logic [W-1:0] e);
    exp_q.push_back(e);
    check(tag, obs);
  endtask

  // ---------------- driver ----------------
  // Pulses start for one edge (E0). It then counts the edges after E0 until
  // done is high and the cycles in which busy was high.
  task automatic run(input logic s, input logic [13:0] wc, input logic [15:0] m,
                     input logic stp, input logic nc, input logic enc,
                     output int edges, output int busy_n, output logic done_e0);
    @(negedge clock);
    sel = s; word_count = wc; mask = m; stop_on_first = stp;
    neg_cycle = nc; exp_neg_cycle = enc;
    start1 = !s; start2 = s;
    @(posedge clock); #1;
    start1 = 1'b0; start2 = 1'b0;
    done_e0 = done_m;
    edges = 0; busy_n = 0;
    while (!done_m && edges < 200) begin
      if (busy_m) busy_n++;
      @(posedge clock); #1;
      edges++;
    end
  endtask

  task automatic fill_mems(input int bad_a, input int bad_b);
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = 16'(i * 16'h1111) ^ 16'hA5A5;
      act_mem[i] = exp_mem[i];
    end
    if (bad_a >= 0) act_mem[bad_a][0] = ~act_mem[bad_a][0];
    if (bad_b >= 0) act_mem[bad_b][0] = ~act_mem[bad_b][0];
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int edges, busy_n;
    logic de0;

    fill_mems(-1, -1);
    #12;
    // Reset values
    ck("rst_busy",  busy1, 0);
    ck("rst_done",  done1, 0);
    ck("rst_pass",  pass1, 0);
    ck("rst_cnt",   cnt1, 0);
    ck("rst_first", first1, 0);
    ck("rst_flag",  flag1, 0);
    ck("rst_aaddr", act_addr1, 0);
    ck("rst_eaddr", exp_addr1, 0);
    @(negedge clock); reset = 1'b1;

    // T1: identical memories, 16 words
    run(0, 16, 16'hFFFF, 0, 0, 0, edges, busy_n, de0);
    ck("t1_edges", edges, 16);
    ck("t1_busy",  busy_n, 16);
    ck("t1_pass",  pass_m, 1);
    ck("t1_cnt",   cnt_m, 0);
    ck("t1_first", first_m, 0);
    ck("t1_flag",  flag1, 0);
    ck("t1_addr",  addr_m, 15);

    // T2a: words 3 and 9 differ in bit 0, full mask
    fill_mems(3, 9);
    run(0, 16, 16'hFFFF, 0, 0, 0, edges, busy_n, de0);
    ck("t2a_edges", edges, 16);
    ck("t2a_cnt",   cnt_m, 2);
    ck("t2a_first", first_m, 3);
    ck("t2a_pass",  pass_m, 0);

    // T2b: bit 0 masked off; restarted straight from DONE
    run(0, 16, 16'hFFFE, 0, 0, 0, edges, busy_n, de0);
    ck("t2b_done_e0", de0, 0);
    ck("t2b_cnt",     cnt_m, 0);
    ck("t2b_first",   first_m, 0);
    ck("t2b_pass",    pass_m, 1);

    // T3: early stop at address 3 ends after edge E4
    run(0, 16, 16'hFFFF, 1, 0, 0, edges, busy_n, de0);
    ck("t3_edges", edges, 4);
    ck("t3_busy",  busy_n, 4);
    ck("t3_cnt",   cnt_m, 1);
    ck("t3_first", first_m, 3);
    ck("t3_addr",  addr_m, 3);
    repeat (3) @(posedge clock);
    #1;
    ck("t3_hold_cnt",  cnt_m, 1);
    ck("t3_hold_done", done_m, 1);

    // T4: empty scan; done right after the start edge, flags disagree
    run(0, 0, 16'hFFFF, 0, 1, 0, edges, busy_n, de0);
    ck("t4_done_e0", de0, 1);
    ck("t4_edges",   edges, 0);
    ck("t4_pass",    pass_m, 0);
    ck("t4_flag",    flag1, 1);
    ck("t4_addr",    addr_m, 0);
    ck("t4_cnt",     cnt_m, 0);

    // T4b: flags only mismatch (memories clean) also fails pass
    fill_mems(-1, -1);
    run(0, 16, 16'hFFFF, 0, 0, 1, edges, busy_n, de0);
    ck("t4b_cnt",  cnt_m, 0);
    ck("t4b_pass", pass_m, 0);

    // T5: small instance, all words mismatch, length clamped 37 -> 32
    run(1, 37, 16'hFFFF, 0, 0, 0, edges, busy_n, de0);
    ck("t5_edges", edges, 32);
    ck("t5_busy",  busy_n, 32);
    ck("t5_cnt",   cnt_m, 15);
    ck("t5_first", first_m, 0);
    ck("t5_addr",  addr_m, 31);
    ck("t5_pass",  pass_m, 0);

    // T6: reset during a 16-word scan with a mismatch at word 3
    fill_mems(3, -1);
    @(negedge clock);
    sel = 0; word_count = 16; mask = 16'hFFFF; stop_on_first = 0;
    neg_cycle = 0; exp_neg_cycle = 0; start1 = 1'b1;
    @(posedge clock); #1; start1 = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    ck("t6_pre_cnt", cnt1, 1);
    reset = 1'b0;
    #1;
    ck("t6_busy",  busy1, 0);
    ck("t6_done",  done1, 0);
    ck("t6_cnt",   cnt1, 0);
    ck("t6_first", first1, 0);
    ck("t6_addr",  act_addr1, 0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    ck("t6_idle_busy", busy1, 0);
    fill_mems(-1, -1);
    run(0, 16, 16'hFFFF, 0, 0, 0, edges, busy_n, de0);
    ck("t6_edges", edges, 16);
    ck("t6_pass",  pass_m, 1);
    ck("t6_cnt2",  cnt_m, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf_result_checker.md
# bf_result_checker

Parametrised self-checking result comparator for the Bellman-Ford benches. After the `bellmanford` core finishes, it scans the DUT output memory (SRAM_1R1W read port) against an expected-result memory (SRAM_1R read port) word by word. It applies a per-bit don't-care mask and compares the NegCycle flag. It reports pass/fail, a saturating mismatch count and the first failing address, replacing manual diffing of dumped memory files. It supports variable scan length and an early-stop mode.

## Interface
Parameters:
- `ADDR_W`, 13, memory address width
- `DATA_W`, 16, output-memory word width
- `DEPTH`, 8192, maximum words per scan; must be ≤ 2^ADDR_W
- `CNT_W`, 14, mismatch counter width; the counter saturates

Ports:
- `clock`  in  1  single clock, rising-edge
- `reset`  in  1  asynchronous, active-low; assertion immediately forces all state to reset values
- `start`  in  1  sampled in IDLE/DONE; begins a scan
- `word_count`  in  ADDR_W+1  words to scan, latched at start; values above DEPTH are clamped to DEPTH
- `mask`  in  DATA_W  1 = bit compared, 0 = don't-care; latched at start
- `stop_on_first`  in  1  latched at start; ends the scan at the first mismatch
- `neg_cycle`  in  1  DUT NegCycle flag, sampled at start
- `exp_neg_cycle`  in  1  expected NegCycle flag, sampled at start
- `act_addr`  out  ADDR_W  read address to the DUT output memory
- `act_data`  in  DATA_W  combinational read data for `act_addr`
- `exp_addr`  out  ADDR_W  read address to the expected memory; always equals `act_addr`
- `exp_data`  in  DATA_W  combinational read data for `exp_addr`
- `busy`  out  1  high in SCAN
- `done`  out  1  high in DONE; held until the next start or reset
- `pass`  out  1  valid while `done`; 1 iff mismatch_count==0 and the flags matched
- `mismatch_count`  out  CNT_W  number of mismatching words
- `first_mismatch_addr`  out  ADDR_W  address of the first mismatching word; 0 if none
- `flag_mismatch`  out  1  neg_cycle != exp_neg_cycle, captured at start

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE/DONE → SCAN when start=1 and clamped word_count>0.
  - IDLE/DONE → DONE when start=1 and word_count=0; this is an empty scan and `pass` reflects only the flag comparison.
  - SCAN → DONE on the last word, or on a mismatch when stop_on_first=1.
- On start:
  - latch the clamped count, mask and stop_on_first
  - set addr←0
  - clear mismatch_count, first_mismatch_addr and the first-seen flag
  - capture flag_mismatch
- SCAN, every cycle:
  - A word mismatches when ((act_data ^ exp_data) & mask) != 0.
  - On a mismatch, increment mismatch_count (saturate at 2^CNT_W−1). If this is the first mismatch, record addr into first_mismatch_addr.
  - Increment addr unless this is the last word.
- Addresses are a registered counter driving both ports. The memories read combinationally, so compare happens in the same cycle as the address.
- `start` is ignored in SCAN. No abort input exists; reset is the only abort.
- The address never wraps. The scan ends at count−1, which is ≤ DEPTH−1.

## Timing
- Reset values: state IDLE; busy=0; done=0; pass=0; mismatch_count=0; first_mismatch_addr=0; flag_mismatch=0; act_addr=exp_addr=0.
- Start sampled at edge E0. Word k is compared between edges Ek and Ek+1, and its result is registered at edge Ek+1.
- For N words with no early stop: done=1 after edge EN, busy is high for exactly N cycles, and throughput is 1 word/cycle.
- Early stop on the first mismatch at address a: done=1 after edge Ea+1.
- mismatch_count and first_mismatch_addr are stable whenever done=1.
- A start that is high in DONE restarts the scan; done drops after the same edge.
- Reset asserted mid-SCAN: outputs go to reset values without waiting for a clock edge. After release, the block waits in IDLE for a new start.

## Structure
- Package `bf_pkg`: the state enum (IDLE/SCAN/DONE) and default width constants (BF_ADDR_W=13, BF_OUT_W=16). The width constants are shared with bellmanford bench plumbing.
- Sub-module `bf_masked_compare`: combinational; inputs a, b, mask; output miss. It is parametrised by DATA_W.
- The top level contains the FSM, the address counter, the saturating counter and the capture registers.

## Test plan
- Identical memories, N=16, mask=16'hFFFF, flags equal: done after 16 cycles, pass=1, mismatch_count=0, first_mismatch_addr=0.
- Words 3 and 9 differ in bit 0, N=16:
  - mask=16'hFFFF: count=2, first=3, pass=0.
  - mask=16'hFFFE: count=0, pass=1.
- Same data as the previous case with stop_on_first=1: done after 4 cycles, count=1, first=3.
- word_count=0 with neg_cycle=1, exp_neg_cycle=0: done after 1 cycle, pass=0, flag_mismatch=1, act_addr never leaves 0.
- CNT_W=4, all 32 words mismatch: count saturates at 15, first=0. Also, word_count=DEPTH+5 scans exactly DEPTH words.
- Reset low at cycle 5 of a 16-word scan: busy, done and counters are 0 immediately. A restart then completes a fresh 16-cycle scan with correct results.
